// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response port of the fetch stage.
// In-order responses; a request is accepted when imem_req && imem_gnt.
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage producing the IF/ID register for decode.
// Define IF_PREFETCH_EN for two outstanding/buffered fetches (DEPTH=2); default DEPTH=1.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      redirect,
    input  logic [31:0]               redirect_pc,
    if_fetch_stage_if.master          imem_bus,
    output logic [31:0]               if_id_inst,
    output logic [31:0]               if_id_pc,
    output logic                      if_id_valid
);

`ifdef IF_PREFETCH_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned CW1 = CW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ibuf_entry_t;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [31:0]                fetch_pc_q,  fetch_pc_n;
    logic [DEPTH-1:0][31:0]     pcq_q,       pcq_n;
    logic [PW-1:0]              pcq_rd_q,    pcq_rd_n;
    logic [PW-1:0]              pcq_wr_q,    pcq_wr_n;
    ibuf_entry_t [DEPTH-1:0]    ibuf_q,      ibuf_n;
    logic [PW-1:0]              ib_rd_q,     ib_rd_n;
    logic [PW-1:0]              ib_wr_q,     ib_wr_n;
    logic [CW-1:0]              ib_cnt_q,    ib_cnt_n;
    logic [CW-1:0]              in_flight_q, in_flight_n;
    logic [CW-1:0]              discard_q,   discard_n;
    logic [31:0]                inst_n,      pc_n;
    logic                       valid_n;

    logic        credit_c;
    logic        grant_c;
    logic        resp_c;
    logic        push_c;
    logic        pop_c;
    logic [31:0] redirect_pc_c;

    // Credit uses registered counts only, so a pop frees a slot one cycle later.
    assign credit_c      = (CW1'(in_flight_q) + CW1'(ib_cnt_q)) < CW1'(DEPTH);
    assign imem_bus.imem_req  = !reset && !redirect && credit_c;
    assign imem_bus.imem_addr = fetch_pc_q;
    assign grant_c       = imem_bus.imem_req && imem_bus.imem_gnt;
    assign resp_c        = imem_bus.imem_rvalid && (in_flight_q != '0) && !reset;
    assign redirect_pc_c = {redirect_pc[31:2], 2'b00};

    always_comb begin
        fetch_pc_n  = fetch_pc_q;
        pcq_n       = pcq_q;
        pcq_rd_n    = pcq_rd_q;
        pcq_wr_n    = pcq_wr_q;
        ibuf_n      = ibuf_q;
        ib_rd_n     = ib_rd_q;
        ib_wr_n     = ib_wr_q;
        ib_cnt_n    = ib_cnt_q;
        discard_n   = discard_q;
        inst_n      = if_id_inst;
        pc_n        = if_id_pc;
        valid_n     = if_id_valid;
        push_c      = 1'b0;
        pop_c       = 1'b0;

        if (grant_c) begin
            pcq_n[pcq_wr_q] = fetch_pc_q;
            pcq_wr_n        = ptr_inc(pcq_wr_q);
            fetch_pc_n      = fetch_pc_q + 32'd4;
        end
        if (resp_c) begin
            pcq_rd_n = ptr_inc(pcq_rd_q);
        end
        in_flight_n = in_flight_q + CW'(grant_c) - CW'(resp_c);

        // Redirect drops the buffer and any same-cycle response; the rest is discarded later.
        if (redirect) begin
            fetch_pc_n = redirect_pc_c;
            ib_rd_n    = '0;
            ib_wr_n    = '0;
            ib_cnt_n   = '0;
            discard_n  = in_flight_q - CW'(resp_c);
            inst_n     = NOP_INST;
            pc_n       = redirect_pc_c;
            valid_n    = 1'b0;
        end else begin
            if (resp_c) begin
                if (discard_q != '0) begin
                    discard_n = discard_q - CW'(1);
                end else begin
                    push_c = 1'b1;
                end
            end
            if (!stall) begin
                if (ib_cnt_q != '0) begin
                    pop_c   = 1'b1;
                    inst_n  = ibuf_q[ib_rd_q].inst;
                    pc_n    = ibuf_q[ib_rd_q].pc;
                    valid_n = 1'b1;
                end else begin
                    inst_n  = NOP_INST;
                    valid_n = 1'b0;
                end
            end
            if (push_c) begin
                ibuf_n[ib_wr_q].pc   = pcq_q[pcq_rd_q];
                ibuf_n[ib_wr_q].inst = imem_bus.imem_rdata;
                ib_wr_n              = ptr_inc(ib_wr_q);
            end
            if (pop_c) begin
                ib_rd_n = ptr_inc(ib_rd_q);
            end
            ib_cnt_n = ib_cnt_q + CW'(push_c) - CW'(pop_c);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            pcq_q       <= '0;
            pcq_rd_q    <= '0;
            pcq_wr_q    <= '0;
            ibuf_q      <= '0;
            ib_rd_q     <= '0;
            ib_wr_q     <= '0;
            ib_cnt_q    <= '0;
            in_flight_q <= '0;
            discard_q   <= '0;
            if_id_inst  <= NOP_INST;
            if_id_pc    <= RESET_PC;
            if_id_valid <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_n;
            pcq_q       <= pcq_n;
            pcq_rd_q    <= pcq_rd_n;
            pcq_wr_q    <= pcq_wr_n;
            ibuf_q      <= ibuf_n;
            ib_rd_q     <= ib_rd_n;
            ib_wr_q     <= ib_wr_n;
            ib_cnt_q    <= ib_cnt_n;
            in_flight_q <= in_flight_n;
            discard_q   <= discard_n;
            if_id_inst  <= inst_n;
            if_id_pc    <= pc_n;
            if_id_valid <= valid_n;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed per-cycle vector bench for if_fetch_stage (table selected by IF_PREFETCH_EN).
module tb_if_fetch_stage;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] I1   = 32'h0010_0093;
    localparam logic [31:0] I2   = 32'h0020_0113;
    localparam logic [31:0] I3   = 32'h0030_0193;
    localparam logic [31:0] I4   = 32'h0040_0213;
    localparam logic [31:0] I5   = 32'h0050_0293;
    localparam logic [31:0] I6   = 32'h0060_0313;
    localparam logic [31:0] I7   = 32'h0070_0393;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic        if_id_valid;

    vec_t vecs[$];
    int   n_cmp;
    int   n_mis;

    if_fetch_stage_if imem_bus();

    if_fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_bus    (imem_bus),
        .if_id_inst  (if_id_inst),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s [step %0d]: got %h, want %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic g, input logic rv, input logic [31:0] rdat,
                       input logic er, input logic [31:0] ea,
                       input logic ev, input logic [31:0] epc, input logic [31:0] einst);
        vec_t v;
        v.stall = st;   v.redirect = rd; v.rpc = rpc;
        v.gnt = g;      v.rvalid = rv;   v.rdata = rdat;
        v.e_req = er;   v.e_addr = ea;
        v.e_valid = ev; v.e_pc = epc;    v.e_inst = einst;
        vecs.push_back(v);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        imem_bus.imem_gnt = 1'b0;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata = 32'h0;

`ifndef IF_PREFETCH_EN
        // stall rdp  rpc           gnt rv rdata   req addr          v  pc            inst
        add(0, 0, 32'h0,         1, 0, 32'h0, 1, 32'h0,         0, 32'h0,         NOP);
        add(0, 0, 32'h0,         0, 1, I1,    0, 32'h4,         0, 32'h0,         NOP);
        add(0, 0, 32'h0,         0, 0, 32'h0, 0, 32'h4,         1, 32'h0,         I1);
        add(0, 0, 32'h0,         1, 0, 32'h0, 1, 32'h4,         0, 32'h0,         NOP);
        add(0, 0, 32'h0,         0, 1, I1,    0, 32'h8,         0, 32'h0,         NOP);
        add(0, 0, 32'h0,         0, 0, 32'h0, 0, 32'h8,         1, 32'h4,         I1);
        add(0, 0, 32'h0,         1, 0, 32'h0, 1, 32'h8,         0, 32'h4,         NOP);
        add(0, 0, 32'h0,         0, 1, I2,    0, 32'hC,         0, 32'h4,         NOP);
        add(0, 0, 32'h0,         0, 0, 32'h0, 0, 32'hC,         1, 32'h8,         I2);
        // five stalled cycles; fetch fills the single credit meanwhile
        add(1, 0, 32'h0,         1, 0, 32'h0, 1, 32'hC,         1, 32'h8,         I2);
        add(1, 0, 32'h0,         0, 1, I3,    0, 32'h10,        1, 32'h8,         I2);
        add(1, 0, 32'h0,         0, 0, 32'h0, 0, 32'h10,        1, 32'h8,         I2);
        add(1, 0, 32'h0,         0, 0, 32'h0, 0, 32'h10,        1, 32'h8,         I2);
        add(1, 0, 32'h0,         0, 0, 32'h0, 0, 32'h10,        1, 32'h8,         I2);
        add(0, 0, 32'h0,         0, 0, 32'h0, 0, 32'h10,        1, 32'hC,         I3);
        // grant withheld for four cycles
        add(0, 0, 32'h0,         0, 0, 32'h0, 1, 32'h10,        0, 32'hC,         NOP);
        add(0, 0, 32'h0,         0, 0, 32'h0, 1, 32'h10,        0, 32'hC,         NOP);
        add(0, 0, 32'h0,         0, 0, 32'h0, 1, 32'h10,        0, 32'hC,         NOP);
        add(0, 0, 32'h0,         0, 0, 32'h0, 1, 32'h10,        0, 32'hC,         NOP);
        add(0, 0, 32'h0,         1, 0, 32'h0, 1, 32'h10,        0, 32'hC,         NOP);
        add(0, 0, 32'h0,         0, 1, I4,    0, 32'h14,        0, 32'hC,         NOP);
        add(0, 0, 32'h0,         0, 0, 32'h0, 0, 32'h14,        1, 32'h10,        I4);
        // redirect with stall and one fetch in flight
        add(0, 0, 32'h0,         1, 0, 32'h0, 1, 32'h14,        0, 32'h10,        NOP);
        add(1, 1, 32'h103,       1, 0, 32'h0, 0, 32'h18,        0, 32'h100,       NOP);
        add(0, 0, 32'h0,         0, 1, JUNK,  0, 32'h100,       0, 32'h100,       NOP);
        add(0, 0, 32'h0,         1, 0, 32'h0, 1, 32'h100,       0, 32'h100,       NOP);
        add(0, 0, 32'h0,         0, 1, I5,    0, 32'h104,       0, 32'h100,       NOP);
        add(0, 0, 32'h0,         0, 0, 32'h0, 0, 32'h104,       1, 32'h100,       I5);
        // response coinciding with redirect is dropped
        add(0, 0, 32'h0,         1, 0, 32'h0, 1, 32'h104,       0, 32'h100,       NOP);
        add(0, 1, 32'h200,       0, 1, JUNK,  0, 32'h108,       0, 32'h200,       NOP);
        add(0, 0, 32'h0,         1, 0, 32'h0, 1, 32'h200,       0, 32'h200,       NOP);
        add(0, 0, 32'h0,         0, 1, I6,    0, 32'h204,       0, 32'h200,       NOP);
        add(0, 0, 32'h0,         0, 0, 32'h0, 0, 32'h204,       1, 32'h200,       I6);
        // fetch PC wraps past the top of the address space
        add(0, 1, 32'hFFFF_FFFE, 0, 0, 32'h0, 0, 32'h204,       0, 32'hFFFF_FFFC, NOP);
        add(0, 0, 32'h0,         1, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, NOP);
        add(0, 0, 32'h0,         0, 1, I7,    0, 32'h0,         0, 32'hFFFF_FFFC, NOP);
        add(0, 0, 32'h0,         0, 0, 32'h0, 0, 32'h0,         1, 32'hFFFF_FFFC, I7);
        add(0, 0, 32'h0,         1, 0, 32'h0, 1, 32'h0,         0, 32'hFFFF_FFFC, NOP);
        add(0, 0, 32'h0,         0, 1, I1,    0, 32'h4,         0, 32'hFFFF_FFFC, NOP);
        add(0, 0, 32'h0,         0, 0, 32'h0, 0, 32'h4,         1, 32'h0,         I1);
        // unsolicited response with nothing in flight
        add(0, 0, 32'h0,         0, 1, JUNK,  1, 32'h4,         0, 32'h0,         NOP);
        add(0, 0, 32'h0,         0, 0, 32'h0, 1, 32'h4,         0, 32'h0,         NOP);
`else
        // two in flight, then redirect to 0x103
        add(0, 0, 32'h0,         1, 0, 32'h0, 1, 32'h0,         0, 32'h0,         NOP);
        add(0, 0, 32'h0,         1, 0, 32'h0, 1, 32'h4,         0, 32'h0,         NOP);
        add(0, 1, 32'h103,       1, 0, 32'h0, 0, 32'h8,         0, 32'h100,       NOP);
        add(0, 0, 32'h0,         0, 1, JUNK,  0, 32'h100,       0, 32'h100,       NOP);
        add(0, 0, 32'h0,         0, 1, JUNK,  1, 32'h100,       0, 32'h100,       NOP);
        add(0, 0, 32'h0,         1, 0, 32'h0, 1, 32'h100,       0, 32'h100,       NOP);
        add(0, 0, 32'h0,         1, 1, I1,    1, 32'h104,       0, 32'h100,       NOP);
        add(0, 0, 32'h0,         0, 1, I2,    0, 32'h108,       1, 32'h100,       I1);
        add(0, 0, 32'h0,         0, 0, 32'h0, 1, 32'h108,       1, 32'h104,       I2);
        // redirect together with stall
        add(1, 1, 32'h100,       0, 0, 32'h0, 0, 32'h108,       0, 32'h100,       NOP);
        add(0, 0, 32'h0,         0, 0, 32'h0, 1, 32'h100,       0, 32'h100,       NOP);
`endif

        // reset state
        @(posedge clk); #1;
        check(-1, "reset imem_req", 32'(imem_bus.imem_req), 32'h0);
        check(-1, "reset if_id_valid", 32'(if_id_valid), 32'h0);
        check(-1, "reset if_id_pc", if_id_pc, 32'h0);
        check(-1, "reset if_id_inst", if_id_inst, NOP);
        check(-1, "reset imem_addr", imem_bus.imem_addr, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (vecs[k]) begin
            stall                = vecs[k].stall;
            redirect             = vecs[k].redirect;
            redirect_pc          = vecs[k].rpc;
            imem_bus.imem_gnt    = vecs[k].gnt;
            imem_bus.imem_rvalid = vecs[k].rvalid;
            imem_bus.imem_rdata  = vecs[k].rdata;
            #1;
            check(k, "imem_req", 32'(imem_bus.imem_req), 32'(vecs[k].e_req));
            check(k, "imem_addr", imem_bus.imem_addr, vecs[k].e_addr);
            @(posedge clk); #1;
            check(k, "if_id_valid", 32'(if_id_valid), 32'(vecs[k].e_valid));
            check(k, "if_id_pc", if_id_pc, vecs[k].e_pc);
            check(k, "if_id_inst", if_id_inst, vecs[k].e_inst);
        end

        // reset with a fetch in flight; the late response must be ignored
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        imem_bus.imem_gnt = 1'b1;
        imem_bus.imem_rvalid = 1'b0;
        #1;
        check(100, "pre-reset imem_req", 32'(imem_bus.imem_req), 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check(101, "in-reset imem_req", 32'(imem_bus.imem_req), 32'h0);
        @(posedge clk); #1;
        check(101, "mid reset if_id_valid", 32'(if_id_valid), 32'h0);
        check(101, "mid reset if_id_pc", if_id_pc, 32'h0);
        check(101, "mid reset if_id_inst", if_id_inst, NOP);
        reset = 1'b0;
        imem_bus.imem_gnt = 1'b0;
        imem_bus.imem_rvalid = 1'b1;
        imem_bus.imem_rdata = JUNK;
        #1;
        check(102, "post-reset imem_req", 32'(imem_bus.imem_req), 32'h1);
        check(102, "post-reset imem_addr", imem_bus.imem_addr, 32'h0);
        @(posedge clk); #1;
        check(102, "post-reset if_id_valid", 32'(if_id_valid), 32'h0);
        imem_bus.imem_rvalid = 1'b0;
        #1;
        check(103, "stale resp imem_req", 32'(imem_bus.imem_req), 32'h1);
        @(posedge clk); #1;
        check(103, "stale resp if_id_valid", 32'(if_id_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
